dp_shifter_operand_stage: RTL

Pipeline stage that resolves the ARMv4 data-processing shifter operand for one instruction at a time.
- Decodes immediate (DPI), immediate-shift (DPIS) and register-shift (DPRS) forms.
- For DPRS, reads Rs from the register file and waits for the read latency.
- Drives the per-type shift units (types 00/01/10/11), then selects and registers their 33-bit {carry, value} result.
- Sits between decode/register read and the ALU, with valid/ready on both sides.

---
 rtl/dp_shifter_operand_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dp_shifter_operand_stage.sv
// ARMv4 data-processing shifter-operand stage: decodes DPI/DPIS/DPRS, fetches Rs, registers {carry, operand}.
// Optional DP_SHIFT_STALL_CNT_EN adds a saturating output-stall counter (stall_cnt).
module dp_shifter_operand_stage #(
    parameter int RS_RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] Rm_data,
    input  logic        C,
    output logic        rs_rd_en,
    output logic [3:0]  rs_addr,
    input  logic [31:0] rs_data,
    output logic [7:0]  shift_amt,
    output logic [31:0] sh_Rm_data,
    output logic        is_DPIS,
    output logic        is_DPRS,
    output logic        sh_C,
    input  logic [32:0] shift_res_00,
    input  logic [32:0] shift_res_01,
    input  logic [32:0] shift_res_10,
    input  logic [32:0] shift_res_11,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] shifter_operand,
    output logic        shifter_carry,
    output logic        out_illegal
`ifdef DP_SHIFT_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RS_WAIT, EXEC, OUT} state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(RS_RD_LATENCY - 1);

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] r);
        return (v >> r) | (v << (6'd32 - {1'b0, r}));
    endfunction

    state_t      state, state_nxt;
    logic [2:0]  cnt_p0, cnt_nxt;
    logic        i25_p0;
    logic [11:0] ilo_p0;
    logic [31:0] rm_p0;
    logic        c_p0;
    logic [7:0]  shift_amt_q;
    logic        can_take, accept, in_dprs;
    logic        dec_dpi, dec_dpis, dec_dprs, dec_ill;
    logic [7:0]  amt_exec;
    logic [31:0] imm_rot, res_val;
    logic        res_carry, res_ill;
    logic        unused_bits;

    assign unused_bits = ^{instr[31:26], instr[24:12], rs_data[31:8]};

    assign in_dprs  = !instr[25] && instr[4] && !instr[7];
    assign dec_dpi  = i25_p0;
    assign dec_dpis = !i25_p0 && !ilo_p0[4];
    assign dec_dprs = !i25_p0 && ilo_p0[4] && !ilo_p0[7];
    assign dec_ill  = !i25_p0 && ilo_p0[4] && ilo_p0[7];

    assign in_ready = can_take && !rst;
    assign accept   = in_ready && in_valid;
    assign rs_addr  = instr[11:8];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_p0;
        can_take  = 1'b0;
        rs_rd_en  = 1'b0;
        case (state)
            IDLE:    can_take = 1'b1;
            RS_WAIT: begin
                cnt_nxt = cnt_p0 - 3'd1;
                if (cnt_p0 == 3'd1) state_nxt = EXEC;
            end
            EXEC:    state_nxt = OUT;
            OUT: begin
                if (out_ready) begin
                    can_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (can_take && !rst && in_valid) begin
            if (in_dprs) begin
                rs_rd_en  = 1'b1;
                cnt_nxt   = WAIT_LOAD;
                state_nxt = (RS_RD_LATENCY == 1) ? EXEC : RS_WAIT;
            end else begin
                state_nxt = EXEC;
            end
        end
    end

    // Stage p0: latched instruction fields and operands, held from accept until the next accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt_p0 <= '0;
            i25_p0 <= 1'b0;
            ilo_p0 <= '0;
            rm_p0  <= '0;
            c_p0   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt_p0 <= cnt_nxt;
            if (accept) begin
                i25_p0 <= instr[25];
                ilo_p0 <= instr[11:0];
                rm_p0  <= Rm_data;
                c_p0   <= C;
            end
        end
    end

    assign amt_exec   = dec_dprs ? rs_data[7:0] : {3'b000, ilo_p0[11:7]};
    assign shift_amt  = (state == EXEC) ? amt_exec : shift_amt_q;
    assign is_DPIS    = (state == EXEC) && dec_dpis;
    assign is_DPRS    = (state == EXEC) && dec_dprs;
    assign sh_Rm_data = rm_p0;
    assign sh_C       = c_p0;
    assign imm_rot    = ror32({24'd0, ilo_p0[7:0]}, {ilo_p0[11:8], 1'b0});

    always_comb begin
        res_val   = rm_p0;
        res_carry = c_p0;
        res_ill   = 1'b0;
        if (dec_dpi) begin
            res_val   = imm_rot;
            res_carry = (ilo_p0[11:8] == 4'd0) ? c_p0 : imm_rot[31];
        end else if (dec_ill) begin
            res_ill = 1'b1;
        end else begin
            case (ilo_p0[6:5])
                2'b00:   {res_carry, res_val} = shift_res_00;
                2'b01:   {res_carry, res_val} = shift_res_01;
                2'b10:   {res_carry, res_val} = shift_res_10;
                default: {res_carry, res_val} = shift_res_11;
            endcase
        end
    end

    // Stage p1: registered result, captured in EXEC and held through OUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter_operand <= '0;
            shifter_carry   <= 1'b0;
            out_illegal     <= 1'b0;
            shift_amt_q     <= '0;
        end else if (state == EXEC) begin
            shifter_operand <= res_val;
            shifter_carry   <= res_carry;
            out_illegal     <= res_ill;
            shift_amt_q     <= amt_exec;
        end
    end

    assign out_valid = (state == OUT);

`ifdef DP_SHIFT_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
